// File: rtl/add32_pkg.sv
// Shared constants and overflow helper for the add32 adder and future ALU blocks.
package add32_pkg;

  localparam int ADD32_WIDTH = 32;
  localparam int CLA_GROUP   = 4;

  // Unsigned overflow is the carry-out for add and the borrow (missing carry) for sub.
  function automatic logic ovf_calc(
    input logic is_sign,
    input logic is_sub,
    input logic a_msb,
    input logic bsel_msb,
    input logic sum_msb,
    input logic cout
  );
    logic ovf;
    if (is_sign) ovf = (a_msb == bsel_msb) && (sum_msb != a_msb);
    else         ovf = is_sub ? ~cout : cout;
    return ovf;
  endfunction

endpackage

// File: rtl/add32_cla4.sv
// 4-bit carry-lookahead group: local sum plus group generate/propagate for the upper tree.
module cla4
  import add32_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] sum,
  output logic                 grp_g,
  output logic                 grp_p
);

  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
  end

endmodule

// File: rtl/add32.sv
// Registered 32-bit add/subtract with unsigned and signed overflow, built on a two-level CLA tree.
module add32
  import add32_pkg::*;
#(
  parameter int WIDTH = ADD32_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_sub,
  input  logic             is_sign,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int NGRP = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] bsel;
  logic [WIDTH-1:0] sum;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP:0]    grp_c;
  logic             term;
  logic             acc;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic             overflow_d;
  logic             overflow_q;

  assign bsel = is_sub ? ~b : b;

  for (genvar i = 0; i < NGRP; i++) begin : g_grp
    cla4 u_cla4 (
      .a     (a[i*CLA_GROUP +: CLA_GROUP]),
      .b     (bsel[i*CLA_GROUP +: CLA_GROUP]),
      .cin   (grp_c[i]),
      .sum   (sum[i*CLA_GROUP +: CLA_GROUP]),
      .grp_g (grp_g[i]),
      .grp_p (grp_p[i])
    );
  end

  // Each group carry is a flat sum of products over all lower groups, so no carry ripples between groups.
  always_comb begin
    term = 1'b0;
    acc  = 1'b0;
    grp_c[0] = is_sub;
    for (int k = 1; k <= NGRP; k++) begin
      acc = 1'b0;
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) term = term & grp_p[m];
        acc = acc | term;
      end
      term = is_sub;
      for (int m = 0; m < k; m++) term = term & grp_p[m];
      grp_c[k] = acc | term;
    end
  end

  always_comb begin
    result_d   = sum;
    overflow_d = ovf_calc(is_sign, is_sub, a[WIDTH-1], bsel[WIDTH-1], sum[WIDTH-1], grp_c[NGRP]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_add32.sv
// Self-checking bench for add32: directed corner cases plus randomized operands against an arithmetic model.
module tb_add32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_sub;
  logic        is_sign;
  logic [31:0] result;
  logic        overflow;

  int total;
  int bad;

  add32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .is_sub   (is_sub),
    .is_sign  (is_sign),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic in 64 bits, then range-check against the chosen interpretation.
  task automatic refModel(input logic [31:0] ma, input logic [31:0] mb, input logic msub,
                          input logic msign, output logic [31:0] r, output logic o);
    longint ua, ub, sa, sb, full;
    longint umax, smax, smin;
    umax = (longint'(1) <<< 32) - 1;
    smax = (longint'(1) <<< 31) - 1;
    smin = -(longint'(1) <<< 31);
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msign) begin
      full = msub ? sa - sb : sa + sb;
      o = (full > smax) || (full < smin);
    end else begin
      full = msub ? ua - ub : ua + ub;
      o = (full < 0) || (full > umax);
    end
    r = full[31:0];
  endtask

  // Drive operands away from the edge, let one rising edge capture them, then settle.
  task automatic applyStimulus(input logic [31:0] sa, input logic [31:0] sb,
                               input logic ssub, input logic ssign);
    @(negedge clk);
    a = sa;
    b = sb;
    is_sub = ssub;
    is_sign = ssign;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp_r, input logic exp_o);
    total++;
    assert (result === exp_r) else begin
      bad++;
      $error("[TB] FAIL %s result got=%h want=%h", tag, result, exp_r);
    end
    total++;
    assert (overflow === exp_o) else begin
      bad++;
      $error("[TB] FAIL %s overflow got=%b want=%b", tag, overflow, exp_o);
    end
  endtask

  initial begin
    logic [31:0] ra, rb, er, held_r;
    logic        ssub, ssign, eo, held_o;

    total = 0;
    bad = 0;
    rst_n = 1'b0;
    a = 32'd100;
    b = 32'd100;
    is_sub = 1'b0;
    is_sign = 1'b0;
    #2;
    checkOutput("reset_idle", 32'h0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", 32'd200, 1'b0);

    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    checkOutput("uadd_wrap", 32'h00000000, 1'b1);
    applyStimulus(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0);
    checkOutput("uadd_max", 32'hFFFFFFFF, 1'b0);
    applyStimulus(32'd5, 32'd7, 1'b1, 1'b0);
    checkOutput("usub_borrow", 32'hFFFFFFFE, 1'b1);
    applyStimulus(32'd7, 32'd5, 1'b1, 1'b0);
    checkOutput("usub_ok", 32'd2, 1'b0);
    applyStimulus(32'h1234ABCD, 32'h1234ABCD, 1'b1, 1'b0);
    checkOutput("usub_equal", 32'd0, 1'b0);
    applyStimulus(32'h7FFFFFFF, 32'd1, 1'b0, 1'b1);
    checkOutput("sadd_ovf", 32'h80000000, 1'b1);
    applyStimulus(32'h80000000, 32'd1, 1'b1, 1'b1);
    checkOutput("ssub_ovf", 32'h7FFFFFFF, 1'b1);
    applyStimulus(32'h00000000, 32'h80000000, 1'b1, 1'b1);
    checkOutput("ssub_minint", 32'h80000000, 1'b1);
    applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
    checkOutput("sadd_neg1", 32'h00000000, 1'b0);
    applyStimulus(32'h0FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    checkOutput("carry_chain", 32'h10000000, 1'b0);
    applyStimulus(32'hFFFF0000, 32'h00010000, 1'b0, 1'b0);
    checkOutput("carry_upper", 32'h00000000, 1'b1);

    // Operands changing between edges must not disturb the registered outputs.
    held_r = result;
    held_o = overflow;
    a = 32'hDEADBEEF;
    b = 32'h12345678;
    is_sub = 1'b1;
    #2;
    checkOutput("hold_between_edges", 32'h00000000, 1'b1);

    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = ra;
      ssub = i[0];
      ssign = i[1];
      applyStimulus(ra, rb, ssub, ssign);
      refModel(ra, rb, ssub, ssign, er, eo);
      checkOutput("random", er, eo);
      if (!ssub && !ssign) begin
        total++;
        assert ((result - ra - rb) == 32'd0) else begin
          bad++;
          $error("[TB] FAIL uadd_identity residue got=%h want=0", result - ra - rb);
        end
      end
    end

    // Reset mid-stream clears immediately; the first edge after release captures fresh operands.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_midstream", 32'h0, 1'b0);
    @(negedge clk);
    a = 32'h00000010;
    b = 32'h00000020;
    is_sub = 1'b1;
    is_sign = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_recapture", 32'hFFFFFFF0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
